// File: rtl/chess_pkg.sv
// Shared types and constants for the chess board engine.
package chess_pkg;

    // Piece codes: 0 empty, 1-6 white, 7-C black, D move hint.
    localparam logic [3:0] PC_EMPTY    = 4'h0;
    localparam logic [3:0] PC_W_PAWN   = 4'h1;
    localparam logic [3:0] PC_W_KNIGHT = 4'h2;
    localparam logic [3:0] PC_W_BISHOP = 4'h3;
    localparam logic [3:0] PC_W_ROOK   = 4'h4;
    localparam logic [3:0] PC_W_QUEEN  = 4'h5;
    localparam logic [3:0] PC_W_KING   = 4'h6;
    localparam logic [3:0] PC_B_PAWN   = 4'h7;
    localparam logic [3:0] PC_B_KNIGHT = 4'h8;
    localparam logic [3:0] PC_B_BISHOP = 4'h9;
    localparam logic [3:0] PC_B_ROOK   = 4'hA;
    localparam logic [3:0] PC_B_QUEEN  = 4'hB;
    localparam logic [3:0] PC_B_KING   = 4'hC;
    localparam logic [3:0] PC_HINT     = 4'hD;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HELD,
        S_UNDO
    } state_t;

    // History fields are sized for the largest supported board (POS_W < 16,
    // CODE_W < 8); the engine zero-extends on push and truncates on pop.
    localparam int unsigned HIST_POS_W  = 16;
    localparam int unsigned HIST_CODE_W = 8;

    typedef struct packed {
        logic [HIST_POS_W-1:0]  from;
        logic [HIST_POS_W-1:0]  to;
        logic [HIST_CODE_W-1:0] piece;
        logic [HIST_CODE_W-1:0] captured;
    } hist_entry_t;

    // Standard start position; row 0 is black's back rank.
    localparam logic [3:0] INIT_BOARD [8][8] = '{
        '{PC_B_ROOK, PC_B_KNIGHT, PC_B_BISHOP, PC_B_QUEEN, PC_B_KING, PC_B_BISHOP, PC_B_KNIGHT, PC_B_ROOK},
        '{PC_B_PAWN, PC_B_PAWN, PC_B_PAWN, PC_B_PAWN, PC_B_PAWN, PC_B_PAWN, PC_B_PAWN, PC_B_PAWN},
        '{PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY},
        '{PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY},
        '{PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY},
        '{PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY, PC_EMPTY},
        '{PC_W_PAWN, PC_W_PAWN, PC_W_PAWN, PC_W_PAWN, PC_W_PAWN, PC_W_PAWN, PC_W_PAWN, PC_W_PAWN},
        '{PC_W_ROOK, PC_W_KNIGHT, PC_W_BISHOP, PC_W_QUEEN, PC_W_KING, PC_W_BISHOP, PC_W_KNIGHT, PC_W_ROOK}
    };

endpackage

// File: rtl/move_history.sv
// Circular LIFO of committed moves; a push into a full buffer overwrites the
// oldest entry and the count saturates at DEPTH.
module move_history #(
    parameter  int unsigned DEPTH = 16,
    parameter  int unsigned WIDTH = 48,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CNT_W = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    top_ptr;

    assign top_ptr  = wr_ptr - AW'(1);
    assign top_data = mem[top_ptr];

    // Pointer and occupancy; pop on an empty history is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (count != CNT_W'(DEPTH))
                count <= count + CNT_W'(1);
        end else if (pop && count != '0) begin
            wr_ptr <= wr_ptr - AW'(1);
            count  <= count - CNT_W'(1);
        end
    end

    // Entry storage; stale contents are unreachable once count is cleared.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/chess_board_engine.sv
// Board store with pick/place/cancel/undo state machine and draw read port.
module chess_board_engine
    import chess_pkg::*;
#(
    parameter  int unsigned         ROWS       = 8,
    parameter  int unsigned         COLS       = 8,
    parameter  int unsigned         CODE_W     = 4,
    parameter  logic [CODE_W-1:0]   HINT_CODE  = CODE_W'(PC_HINT),
    parameter  int unsigned         HIST_DEPTH = 16,
    localparam int unsigned         RW         = $clog2(ROWS),
    localparam int unsigned         CW         = $clog2(COLS),
    localparam int unsigned         POS_W      = RW + CW,
    localparam int unsigned         HCNT_W     = $clog2(HIST_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [POS_W-1:0]       figure_xy,
    input  logic [POS_W-1:0]       figure_position,
    input  logic                   pick_piece,
    input  logic                   place_piece,
    input  logic                   cancel,
    input  logic                   undo,
    input  logic [ROWS*COLS-1:0]   possible_moves,
    output logic [CODE_W-1:0]      board [ROWS][COLS],
    output logic [CODE_W-1:0]      figure_code,
    output logic [CODE_W-1:0]      figure_taken,
    output logic [POS_W-1:0]       pp_pos,
    output logic                   holding,
    output logic                   move_done,
    output logic [CODE_W-1:0]      captured,
    output logic [HCNT_W-1:0]      hist_count
);

    state_t state;

    logic [RW-1:0]     pos_r, xy_r, pp_r, from_r, to_r;
    logic [CW-1:0]     pos_c, xy_c, pp_c, from_c, to_c;
    logic [CODE_W-1:0] pos_code, xy_code;
    logic              pos_legal;
    logic              is_cancel, is_commit;
    hist_entry_t       push_e, top_e;
    logic              hist_push, hist_pop;
    logic              hist_pad_unused;

    assign pos_r    = figure_position[POS_W-1:CW];
    assign pos_c    = figure_position[CW-1:0];
    assign xy_r     = figure_xy[POS_W-1:CW];
    assign xy_c     = figure_xy[CW-1:0];
    assign pp_r     = pp_pos[POS_W-1:CW];
    assign pp_c     = pp_pos[CW-1:0];
    assign pos_code = board[pos_r][pos_c];
    assign xy_code  = board[xy_r][xy_c];

    // Square index row*COLS+col equals the {row, col} concatenation.
    assign pos_legal = possible_moves[figure_position];

    // Placing back on the origin behaves exactly like cancel.
    assign is_cancel = (state == S_HELD) &&
                       (cancel || (place_piece && figure_position == pp_pos));
    assign is_commit = (state == S_HELD) && !is_cancel && place_piece && pos_legal;

    assign hist_push = is_commit;
    assign hist_pop  = (state == S_UNDO);

    assign push_e.from     = HIST_POS_W'(pp_pos);
    assign push_e.to       = HIST_POS_W'(figure_position);
    assign push_e.piece    = HIST_CODE_W'(figure_taken);
    assign push_e.captured = HIST_CODE_W'(pos_code);

    assign from_r = top_e.from[POS_W-1:CW];
    assign from_c = top_e.from[CW-1:0];
    assign to_r   = top_e.to[POS_W-1:CW];
    assign to_c   = top_e.to[CW-1:0];

    assign hist_pad_unused = ^{top_e.from[HIST_POS_W-1:POS_W], top_e.to[HIST_POS_W-1:POS_W],
                               top_e.piece[HIST_CODE_W-1:CODE_W],
                               top_e.captured[HIST_CODE_W-1:CODE_W]};

    function automatic logic [CODE_W-1:0] init_square(input int unsigned r, input int unsigned c);
        if (ROWS == 8 && COLS == 8)
            return CODE_W'(INIT_BOARD[r[2:0]][c[2:0]]);
        return '0;
    endfunction

    move_history #(
        .DEPTH (HIST_DEPTH),
        .WIDTH ($bits(hist_entry_t))
    ) u_history (
        .clk       (clk),
        .rst       (rst),
        .push      (hist_push),
        .pop       (hist_pop),
        .push_data (push_e),
        .top_data  (top_e),
        .count     (hist_count)
    );

    // Board store, pick/place/undo state machine and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            figure_code  <= '0;
            figure_taken <= '0;
            pp_pos       <= '0;
            holding      <= 1'b0;
            move_done    <= 1'b0;
            captured     <= '0;
            for (int unsigned r = 0; r < ROWS; r++)
                for (int unsigned c = 0; c < COLS; c++)
                    board[r][c] <= init_square(r, c);
        end else begin
            move_done   <= 1'b0;
            figure_code <= (xy_code == '0 && possible_moves[figure_xy]) ? HINT_CODE : xy_code;
            case (state)
                S_IDLE: begin
                    if (pick_piece) begin
                        if (pos_code != '0) begin
                            figure_taken        <= pos_code;
                            pp_pos              <= figure_position;
                            board[pos_r][pos_c] <= '0;
                            holding             <= 1'b1;
                            state               <= S_HELD;
                        end
                    end else if (undo && hist_count != '0) begin
                        state <= S_UNDO;
                    end
                end
                S_HELD: begin
                    if (is_cancel) begin
                        board[pp_r][pp_c] <= figure_taken;
                        holding           <= 1'b0;
                        state             <= S_IDLE;
                    end else if (is_commit) begin
                        board[pos_r][pos_c] <= figure_taken;
                        captured            <= pos_code;
                        move_done           <= 1'b1;
                        holding             <= 1'b0;
                        state               <= S_IDLE;
                    end
                end
                S_UNDO: begin
                    board[from_r][from_c] <= CODE_W'(top_e.piece);
                    board[to_r][to_c]     <= CODE_W'(top_e.captured);
                    state                 <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chess_board_engine.sv
// Directed self-checking bench for chess_board_engine (8x8, depth 16).
module tb_chess_board_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  figure_xy = '0;
    logic [5:0]  figure_position = '0;
    logic        pick_piece = 1'b0;
    logic        place_piece = 1'b0;
    logic        cancel = 1'b0;
    logic        undo = 1'b0;
    logic [63:0] possible_moves = '0;
    logic [3:0]  board [8][8];
    logic [3:0]  figure_code;
    logic [3:0]  figure_taken;
    logic [5:0]  pp_pos;
    logic        holding;
    logic        move_done;
    logic [3:0]  captured;
    logic [4:0]  hist_count;

    int unsigned passed = 0;
    int unsigned total  = 0;

    chess_board_engine #(
        .ROWS       (8),
        .COLS       (8),
        .CODE_W     (4),
        .HINT_CODE  (4'hD),
        .HIST_DEPTH (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .figure_xy       (figure_xy),
        .figure_position (figure_position),
        .pick_piece      (pick_piece),
        .place_piece     (place_piece),
        .cancel          (cancel),
        .undo            (undo),
        .possible_moves  (possible_moves),
        .board           (board),
        .figure_code     (figure_code),
        .figure_taken    (figure_taken),
        .pp_pos          (pp_pos),
        .holding         (holding),
        .move_done       (move_done),
        .captured        (captured),
        .hist_count      (hist_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [5:0] sq(input int r, input int c);
        return 6'(r * 8 + c);
    endfunction

    task automatic do_move(input logic [5:0] from, input logic [5:0] to, input string tag);
        figure_position = from;
        pick_piece      = 1'b1;
        tick();
        pick_piece = 1'b0;
        check({tag, "_held"}, 32'(holding), 32'd1);
        figure_position = to;
        place_piece     = 1'b1;
        tick();
        place_piece = 1'b0;
        check({tag, "_done"}, 32'(move_done), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset and initial position
        #1 rst = 1'b1;
        figure_xy = sq(7, 4);
        tick();
        tick();
        rst = 1'b0;
        check("rst_king_w", 32'(board[7][4]), 32'h6);
        check("rst_king_b", 32'(board[0][4]), 32'hC);
        check("rst_holding", 32'(holding), 32'd0);
        check("rst_hist", 32'(hist_count), 32'd0);
        check("rst_fcode", 32'(figure_code), 32'd0);
        tick();
        check("fcode_74", 32'(figure_code), 32'h6);

        // Legal pawn move e2-e4 style, with hint on the read port
        possible_moves = (64'd1 << 36) | (64'd1 << 44);
        figure_xy       = sq(5, 4);
        figure_position = sq(6, 4);
        pick_piece      = 1'b1;
        tick();
        pick_piece = 1'b0;
        check("pick_holding", 32'(holding), 32'd1);
        check("pick_taken", 32'(figure_taken), 32'd1);
        check("pick_pp_pos", 32'(pp_pos), 32'd52);
        check("pick_cleared", 32'(board[6][4]), 32'd0);
        check("hint_code", 32'(figure_code), 32'hD);
        figure_position = sq(4, 4);
        place_piece     = 1'b1;
        tick();
        place_piece = 1'b0;
        check("mv_done", 32'(move_done), 32'd1);
        check("mv_captured", 32'(captured), 32'd0);
        check("mv_target", 32'(board[4][4]), 32'd1);
        check("mv_origin", 32'(board[6][4]), 32'd0);
        check("mv_hist", 32'(hist_count), 32'd1);
        check("mv_holding", 32'(holding), 32'd0);
        tick();
        check("mv_done_pulse", 32'(move_done), 32'd0);

        // Illegal place is ignored, then cancel returns the piece
        possible_moves  = 64'd1 << 35;
        figure_position = sq(6, 3);
        pick_piece      = 1'b1;
        tick();
        pick_piece      = 1'b0;
        figure_position = sq(3, 3);
        place_piece     = 1'b1;
        tick();
        place_piece = 1'b0;
        check("ill_holding", 32'(holding), 32'd1);
        check("ill_target", 32'(board[3][3]), 32'd0);
        check("ill_done", 32'(move_done), 32'd0);
        check("ill_hist", 32'(hist_count), 32'd1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cxl_holding", 32'(holding), 32'd0);
        check("cxl_origin", 32'(board[6][3]), 32'd1);
        check("cxl_hist", 32'(hist_count), 32'd1);
        check("cxl_done", 32'(move_done), 32'd0);

        // Capture of a black pawn, then undo it
        possible_moves = 64'd1 << 11;
        do_move(sq(4, 4), sq(1, 3), "cap");
        check("cap_captured", 32'(captured), 32'd7);
        check("cap_target", 32'(board[1][3]), 32'd1);
        check("cap_origin", 32'(board[4][4]), 32'd0);
        check("cap_hist", 32'(hist_count), 32'd2);
        undo = 1'b1;
        tick();
        undo = 1'b0;
        check("undo_pending_hist", 32'(hist_count), 32'd2);
        tick();
        check("undo_victim", 32'(board[1][3]), 32'd7);
        check("undo_piece", 32'(board[4][4]), 32'd1);
        check("undo_hist", 32'(hist_count), 32'd1);
        check("undo_captured_kept", 32'(captured), 32'd7);

        // Reset while holding restores the start position
        figure_position = sq(7, 4);
        pick_piece      = 1'b1;
        tick();
        pick_piece = 1'b0;
        check("rh_holding", 32'(holding), 32'd1);
        check("rh_cleared", 32'(board[7][4]), 32'd0);
        possible_moves  = '1;
        figure_position = sq(5, 4);
        place_piece     = 1'b1;
        rst             = 1'b1;
        #2;
        check("rh_king", 32'(board[7][4]), 32'h6);
        check("rh_pawn", 32'(board[6][4]), 32'd1);
        check("rh_e4", 32'(board[4][4]), 32'd0);
        check("rh_holding0", 32'(holding), 32'd0);
        check("rh_hist", 32'(hist_count), 32'd0);
        tick();
        rst         = 1'b0;
        place_piece = 1'b0;
        tick();
        check("rh_no_done", 32'(move_done), 32'd0);
        check("rh_target_empty", 32'(board[5][4]), 32'd0);

        // HIST_DEPTH+2 moves saturate the history
        possible_moves = '1;
        do_move(sq(6, 0), sq(5, 0), "old1");
        do_move(sq(6, 7), sq(5, 7), "old2");
        for (int m = 3; m <= 18; m++) begin
            if (m % 2 == 1)
                do_move(sq(7, 6), sq(5, 5), "kn");
            else
                do_move(sq(5, 5), sq(7, 6), "kn");
        end
        check("sat_hist", 32'(hist_count), 32'd16);

        // Undo held high: one move per two cycles
        undo = 1'b1;
        tick();
        tick();
        check("u1_hist", 32'(hist_count), 32'd15);
        check("u1_kn_at_55", 32'(board[5][5]), 32'd2);
        check("u1_76_empty", 32'(board[7][6]), 32'd0);
        for (int i = 0; i < 30; i++)
            tick();
        check("u16_hist", 32'(hist_count), 32'd0);
        check("u16_kn_home", 32'(board[7][6]), 32'd2);
        check("u16_55_empty", 32'(board[5][5]), 32'd0);
        check("u16_old1_to", 32'(board[5][0]), 32'd1);
        check("u16_old1_from", 32'(board[6][0]), 32'd0);
        check("u16_old2_to", 32'(board[5][7]), 32'd1);
        check("u16_old2_from", 32'(board[6][7]), 32'd0);
        for (int i = 0; i < 4; i++)
            tick();
        undo = 1'b0;
        check("uempty_hist", 32'(hist_count), 32'd0);
        check("uempty_kn", 32'(board[7][6]), 32'd2);
        check("uempty_55", 32'(board[5][5]), 32'd0);
        check("uempty_old1", 32'(board[5][0]), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
